l2_sq_accum: RTL and testbench

Parametrised, pipelined sum-of-squares engine for the L2-norm datapath. It squares a stream of signed samples and accumulates VEC_LEN of them into one result. It then presents the result with a per-vector overflow flag on a valid/ready output, and clears itself for the next vector. This is the next generation of the single-channel MAC stage: generic widths, automatic vector framing, output backpressure and optional saturation.

---
 rtl/l2_sq_accum.sv | 109 ++++++++++
 tb/tb_l2_sq_accum.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/l2_sq_accum.sv
// l2_sq_accum: pipelined sum-of-squares engine for the L2-norm datapath.
// Squares signed samples and accumulates VEC_LEN of them per result. Each
// result is presented with a per-vector overflow flag on a valid/ready output.
// Optional feature macro: SATURATE_EN. When it is defined, sums clamp to
// 2^ACC_W-1 on overflow; when it is undefined, sums wrap modulo 2^ACC_W.
module l2_sq_accum #(
  parameter int IN_W    = 8,
  parameter int ACC_W   = 20,
  parameter int VEC_LEN = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic signed [IN_W-1:0] a,
  input  logic                   valid_in,
  output logic                   ready_in,
  output logic [ACC_W-1:0]       f,
  output logic                   valid_out,
  input  logic                   ready_out,
  output logic                   overflow
);

  localparam int CNT_W = $clog2(VEC_LEN + 1);
  localparam int P_W   = 2 * IN_W;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VEC_LEN - 1);

  logic                   stall;
  logic                   accept;
  logic signed [P_W-1:0]  a_ext;
  logic signed [P_W-1:0]  sq;
  logic [P_W-1:0]         p_prod;
  logic                   p_valid;
  logic                   p_last;
  logic [CNT_W-1:0]       cnt;
  logic [ACC_W-1:0]       acc;
  logic                   ovf_acc;
  logic [ACC_W:0]         sum;
  logic                   ovf_now;
  logic [ACC_W-1:0]       acc_next;

  // A pending, unaccepted result freezes the whole pipeline.
  assign stall    = valid_out && !ready_out;
  assign ready_in = !stall;
  assign accept   = valid_in && ready_in;

  // The square of a two's complement value always fits in 2*IN_W unsigned bits.
  assign a_ext = {{IN_W{a[IN_W-1]}}, a};
  assign sq    = a_ext * a_ext;

  // Stage 1 registers the square and tags the last element of each vector.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_valid <= 1'b0;
      p_last  <= 1'b0;
      p_prod  <= '0;
      cnt     <= '0;
    end else if (!stall) begin
      p_valid <= accept;
      if (accept) begin
        p_prod <= sq;
        p_last <= (cnt == LAST_IDX);
        cnt    <= (cnt == LAST_IDX) ? '0 : cnt + CNT_W'(1);
      end
    end
  end

  // The accumulate sum uses one extra bit, so the carry-out marks an overflow.
  always_comb begin
    sum     = {1'b0, acc} + {{(ACC_W + 1 - P_W){1'b0}}, p_prod};
    ovf_now = ovf_acc | sum[ACC_W];
`ifdef SATURATE_EN
    acc_next = ovf_now ? '1 : sum[ACC_W-1:0];
`else
    acc_next = sum[ACC_W-1:0];
`endif
  end

  // Stage 2 accumulates and clears itself as the last element retires.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc     <= '0;
      ovf_acc <= 1'b0;
    end else if (!stall && p_valid) begin
      if (p_last) begin
        acc     <= '0;
        ovf_acc <= 1'b0;
      end else begin
        acc     <= acc_next;
        ovf_acc <= ovf_now;
      end
    end
  end

  // The output register loads on the last element and is popped by ready_out.
  // A load on a popping edge replaces the old result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      f         <= '0;
      overflow  <= 1'b0;
      valid_out <= 1'b0;
    end else if (!stall && p_valid && p_last) begin
      f         <= acc_next;
      overflow  <= ovf_now;
      valid_out <= 1'b1;
    end else if (ready_out) begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_l2_sq_accum.sv
// Testbench for l2_sq_accum. It drives two instances with the same stimulus.
// One instance has ACC_W=20 (default) and the other has ACC_W=16, which makes
// overflow reachable. Each expected result comes from a reference model that
// computes an exact integer sum of squares for each vector.
module tb_l2_sq_accum;

  localparam int IN_W    = 8;
  localparam int VEC_LEN = 4;
  localparam int ACC_A   = 20;
  localparam int ACC_B   = 16;

  logic                   clk = 1'b0;
  logic                   reset;
  logic signed [IN_W-1:0] a;
  logic                   valid_in;
  logic                   ready_out;
  logic                   ready_a, ready_b;
  logic [ACC_A-1:0]       f_a;
  logic [ACC_B-1:0]       f_b;
  logic                   vout_a, vout_b;
  logic                   ovf_a, ovf_b;

  int n_tests = 0;
  int n_fail  = 0;

  longint exp_q[$];
  longint psum = 0;
  int     pcnt = 0;
  bit     rand_bp = 1'b0;

  always #5 clk = ~clk;

  l2_sq_accum #(.IN_W(IN_W), .ACC_W(ACC_A), .VEC_LEN(VEC_LEN)) dut_a (
    .clk(clk), .reset(reset), .a(a), .valid_in(valid_in), .ready_in(ready_a),
    .f(f_a), .valid_out(vout_a), .ready_out(ready_out), .overflow(ovf_a)
  );

  l2_sq_accum #(.IN_W(IN_W), .ACC_W(ACC_B), .VEC_LEN(VEC_LEN)) dut_b (
    .clk(clk), .reset(reset), .a(a), .valid_in(valid_in), .ready_in(ready_b),
    .f(f_b), .valid_out(vout_b), .ready_out(ready_out), .overflow(ovf_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint exp_f(input longint s, input int w);
    longint maxv = (longint'(1) << w) - 1;
    if (s > maxv) begin
`ifdef SATURATE_EN
      return maxv;
`else
      return s & maxv;
`endif
    end
    return s;
  endfunction

  function automatic bit exp_ovf(input longint s, input int w);
    return s > ((longint'(1) << w) - 1);
  endfunction

  // Scoreboard: each handshake on the output retires one expected vector.
  longint s_mon;
  always @(negedge clk) begin
    if (reset && ready_out && (vout_a || vout_b)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        s_mon = exp_q.pop_front();
        check("vout20", vout_a, 1);
        check("vout16", vout_b, 1);
        check("f20", f_a, exp_f(s_mon, ACC_A));
        check("ovf20", ovf_a, exp_ovf(s_mon, ACC_A));
        check("f16", f_b, exp_f(s_mon, ACC_B));
        check("ovf16", ovf_b, exp_ovf(s_mon, ACC_B));
      end
    end
  end

  // Random backpressure on the output side.
  always @(posedge clk) begin
    if (rand_bp) begin
      #1;
      ready_out = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic model_accept(input int v);
    psum += longint'(v * v);
    pcnt++;
    if (pcnt == VEC_LEN) begin
      exp_q.push_back(psum);
      psum = 0;
      pcnt = 0;
    end
  endtask

  // Presents one sample and holds it until the block takes it.
  task automatic send(input int v);
    logic rdy;
    logic [31:0] vv;
    vv = v;
    a = vv[IN_W-1:0];
    valid_in = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      rdy = ready_a;
      @(posedge clk);
      #1;
      if (rdy) begin
        model_accept(v);
        valid_in = 1'b0;
        return;
      end
    end
    check("send_timeout", 0, 1);
    valid_in = 1'b0;
  endtask

  task automatic send_vec(input int v0, input int v1, input int v2, input int v3);
    send(v0); send(v1); send(v2); send(v3);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; valid_in = 1'b0; a = '0; ready_out = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_vout", vout_a, 0);
    check("rst_f", f_a, 0);
    check("rst_ovf", ovf_a, 0);
    check("rst_ready_in", ready_a, 1);
    tick();
    reset = 1'b1;
    idle(2);

    // Basic vector with exact latency: the result shows 2 edges after -6.
    send(3); send(-4); send(5); send(-6);
    @(negedge clk); check("lat_edge1", vout_a, 0);
    @(negedge clk); check("lat_edge2", vout_a, 1);
    check("basic_f", f_a, 86);
    @(negedge clk); check("lat_edge3", vout_a, 0);
    tick();

    // Extremes; -128s overflow the 16-bit instance.
    send_vec(-128, -128, -128, -128);
    send_vec(127, 127, 127, 127);
    send_vec(1, 1, 1, 1);
    idle(6);

    // Backpressure: the result is held while a new sample waits.
    ready_out = 1'b0;
    send_vec(3, -4, 5, -6);
    tick();
    valid_in = 1'b1;
    a = 8'sd2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_ready_in", ready_a, 0);
      check("bp_valid", vout_a, 1);
      check("bp_hold_f", f_a, 86);
      tick();
    end
    ready_out = 1'b1;
    valid_in = 1'b0;
    send_vec(2, 2, 2, 2);
    idle(6);

    // Gaps in valid_in.
    send(1); idle(1); send(2); idle(2); send(3); send(4);
    idle(6);

    // Reset mid-vector discards the partial sum.
    send(9); send(9);
    reset = 1'b0;
    @(negedge clk);
    check("mrst_vout", vout_a, 0);
    check("mrst_f", f_a, 0);
    check("mrst_ready_in", ready_a, 1);
    tick();
    reset = 1'b1;
    psum = 0; pcnt = 0; exp_q.delete();
    send_vec(1, 1, 1, 1);
    idle(6);

    // Random samples, random gaps and random backpressure.
    rand_bp = 1'b1;
    for (int k = 0; k < 160; k++) begin
      send(int'($urandom_range(0, 255)) - 128);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
    end
    rand_bp = 1'b0;
    tick();
    ready_out = 1'b1;
    idle(8);
    check("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
